// File: rtl/inv_mix_columns_seq.sv
// Sequential AES (Inv)MixColumns: one 32-bit column per clock through a shared
// GF(2^8) column engine, valid/ready handshake on both sides.
module inv_mix_columns_seq #(
    parameter bit INVERSE = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COL  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Row-0 coefficients; each further row rotates them right by one.
    localparam logic [7:0] K0 = INVERSE ? 8'h0e : 8'h02;
    localparam logic [7:0] K1 = INVERSE ? 8'h0b : 8'h03;
    localparam logic [7:0] K2 = INVERSE ? 8'h0d : 8'h01;
    localparam logic [7:0] K3 = INVERSE ? 8'h09 : 8'h01;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] k);
        logic [7:0] x2, x4, x8, p;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        case (k)
            8'h01:   p = a;
            8'h02:   p = x2;
            8'h03:   p = x2 ^ a;
            8'h09:   p = x8 ^ a;
            8'h0b:   p = x8 ^ x2 ^ a;
            8'h0d:   p = x8 ^ x4 ^ a;
            8'h0e:   p = x8 ^ x4 ^ x2;
            default: p = 8'h00;
        endcase
        return p;
    endfunction

    state_e            state_q, state_d;
    logic [1:0]        col_q, col_d;
    logic [3:0][31:0]  in_q, in_d;      // index 3 is column 0 (most significant)
    logic [3:0][31:0]  work_q, work_d;
    logic [31:0]       col_in, col_out;
    logic [7:0]        a0, a1, a2, a3;

    // Column engine: ~col_q maps column number to packed slot.
    always_comb begin
        col_in  = in_q[~col_q];
        a0      = col_in[31:24];
        a1      = col_in[23:16];
        a2      = col_in[15:8];
        a3      = col_in[7:0];
        col_out = {gf_mul(a0, K0) ^ gf_mul(a1, K1) ^ gf_mul(a2, K2) ^ gf_mul(a3, K3),
                   gf_mul(a0, K3) ^ gf_mul(a1, K0) ^ gf_mul(a2, K1) ^ gf_mul(a3, K2),
                   gf_mul(a0, K2) ^ gf_mul(a1, K3) ^ gf_mul(a2, K0) ^ gf_mul(a3, K1),
                   gf_mul(a0, K1) ^ gf_mul(a1, K2) ^ gf_mul(a2, K3) ^ gf_mul(a3, K0)};
    end

    // NOTE: every *_d gets its hold value first so no path leaves a latch behind.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        in_d    = in_q;
        work_d  = work_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    in_d    = state_in;
                    col_d   = 2'd0;
                    state_d = COL;
                end
            end
            COL: begin
                work_d[~col_q] = col_out;
                col_d          = col_q + 2'd1;
                if (col_q == 2'd3) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            col_q   <= 2'd0;
            in_q    <= '0;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            in_q    <= in_d;
            work_q  <= work_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign state_out = work_q;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Self-checking bench for inv_mix_columns_seq: directed FIPS vectors, handshake
// timing, reset abort, forward->inverse round trip and streaming throughput.
module tb_inv_mix_columns_seq;

    logic         clk = 1'b0;
    logic         reset, in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] state_in, state_out;

    logic         rt_valid, fwd_ready, fwd_valid, fwd_busy;
    logic         inv_ready, inv_valid, inv_busy, rt_out_ready;
    logic [127:0] rt_data, fwd_out, inv_out;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    inv_mix_columns_seq #(.INVERSE(1'b1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .state_in(state_in), .out_valid(out_valid), .out_ready(out_ready),
        .state_out(state_out), .busy(busy));

    inv_mix_columns_seq #(.INVERSE(1'b0)) fwd (
        .clk(clk), .reset(reset), .in_valid(rt_valid), .in_ready(fwd_ready),
        .state_in(rt_data), .out_valid(fwd_valid), .out_ready(inv_ready),
        .state_out(fwd_out), .busy(fwd_busy));

    inv_mix_columns_seq #(.INVERSE(1'b1)) inv (
        .clk(clk), .reset(reset), .in_valid(fwd_valid), .in_ready(inv_ready),
        .state_in(fwd_out), .out_valid(inv_valid), .out_ready(rt_out_ready),
        .state_out(inv_out), .busy(inv_busy));

    // Reference: schoolbook GF(2^8) product and a full 4x4 matrix per column.
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        logic       hi;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            hi = x[7];
            x  = {x[6:0], 1'b0};
            if (hi) x = x ^ 8'h1b;
            y  = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_imc(input logic [127:0] s);
        logic [7:0]   a [16];
        logic [7:0]   base [4];
        logic [7:0]   acc;
        logic [127:0] r;
        base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        r    = '0;
        for (int k = 0; k < 16; k++) a[k] = s[127-8*k -: 8];
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ ref_mul(base[(j - row + 4) % 4], a[4*c + j]);
                r[127-8*(4*c+row) -: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] rand_state();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 30) begin
            tick();
            n++;
        end
    endtask

    // Accept one state from IDLE, check latency and result, then drain it.
    task automatic send_check(input string name, input logic [127:0] v, input logic [127:0] exp);
        int n;
        state_in = v;
        in_valid = 1'b1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s in_ready: got %b expected 1", name, in_ready);
        end
        tick();
        in_valid = 1'b0;
        wait_out(n);
        n_cmp++;
        if (out_valid !== 1'b1 || n != 4) begin
            n_bad++;
            $display("FAIL %s latency: got %0d (out_valid=%b) expected 4", name, n, out_valid);
        end
        n_cmp++;
        if (state_out !== exp) begin
            n_bad++;
            $display("FAIL %s data: got %h expected %h", name, state_out, exp);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL %s drain: out_valid got %b expected 0", name, out_valid);
        end
    endtask

    task automatic test_reset();
        bit seen;
        reset = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset out_valid: got %b expected 0", out_valid); end
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL reset busy: got %b expected 0", busy); end
        n_cmp++;
        if (state_out !== 128'h0) begin n_bad++; $display("FAIL reset state_out: got %h expected 0", state_out); end
        reset = 1'b0;
        tick();
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset in_ready: got %b expected 1", in_ready); end
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
            tick();
        end
        n_cmp++;
        if (seen) begin n_bad++; $display("FAIL reset idle: got activity expected none"); end
    endtask

    localparam logic [127:0] FIPS_IN  = {32'h8e4da1bc, 32'h9fdc589d, 32'h4d7ebdf8, 32'hc6c6c6c6};
    localparam logic [127:0] FIPS_OUT = {32'hdb135345, 32'hf20a225c, 32'h2d26314c, 32'hc6c6c6c6};

    task automatic test_fips();
        send_check("fips", FIPS_IN, FIPS_OUT);
    endtask

    task automatic test_backpressure();
        logic [127:0] v2;
        int           n;
        bit           bad_hold;
        v2       = rand_state();
        state_in = FIPS_IN;
        in_valid = 1'b1;
        tick();
        wait_out(n);
        n_cmp++;
        if (out_valid !== 1'b1 || n != 4) begin
            n_bad++;
            $display("FAIL bp latency: got %0d expected 4", n);
        end
        state_in = v2;
        in_valid = 1'b1;
        bad_hold = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (state_out !== FIPS_OUT || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
                bad_hold = 1'b1;
                $display("FAIL bp hold cycle %0d: got %h ov=%b ir=%b expected %h ov=1 ir=0",
                         i, state_out, out_valid, in_ready, FIPS_OUT);
            end
            tick();
        end
        n_cmp++;
        if (bad_hold) n_bad++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL bp release: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL bp second accept: busy got %b expected 1", busy); end
        wait_out(n);
        n_cmp++;
        if (out_valid !== 1'b1 || state_out !== ref_imc(v2)) begin
            n_bad++;
            $display("FAIL bp second data: got %h expected %h", state_out, ref_imc(v2));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit seen;
        state_in = rand_state();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || state_out !== 128'h0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL midreset state: ov=%b busy=%b ir=%b out=%h expected 0/0/1/0",
                     out_valid, busy, in_ready, state_out);
        end
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid !== 1'b0) seen = 1'b1;
            tick();
        end
        n_cmp++;
        if (seen) begin n_bad++; $display("FAIL midreset aborted: got out_valid expected none"); end
        send_check("midreset ones", {16{8'h01}}, {16{8'h01}});
    endtask

    task automatic test_round_trip();
        logic [127:0] q [$];
        logic [127:0] e;
        int           sent, got, guard;
        bit           acc;
        sent = 0; got = 0; guard = 0;
        rt_out_ready = 1'b1;
        rt_data      = {16{8'hff}};
        rt_valid     = 1'b1;
        while (got < 1000 && guard < 20000) begin
            acc = rt_valid && fwd_ready;
            if (acc) q.push_back(rt_data);
            if (inv_valid) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL roundtrip extra: got %h expected nothing", inv_out);
                end else begin
                    e = q.pop_front();
                    if (inv_out !== e) begin
                        n_bad++;
                        $display("FAIL roundtrip %0d: got %h expected %h", got, inv_out, e);
                    end
                end
                got++;
            end
            tick();
            guard++;
            if (acc) begin
                sent++;
                if (sent == 1)        rt_data = {16{8'h80}};
                else if (sent < 1000) rt_data = rand_state();
                else                  rt_valid = 1'b0;
            end
        end
        rt_valid     = 1'b0;
        rt_out_ready = 1'b0;
        n_cmp++;
        if (got != 1000) begin n_bad++; $display("FAIL roundtrip count: got %0d expected 1000", got); end
    endtask

    task automatic test_throughput();
        logic [127:0] v [8];
        logic [127:0] q [$];
        logic [127:0] e;
        int           acc_cyc [$];
        int           sent, got, guard;
        bit           acc;
        for (int i = 0; i < 8; i++) v[i] = rand_state();
        sent = 0; got = 0; guard = 0;
        state_in  = v[0];
        in_valid  = 1'b1;
        out_ready = 1'b1;
        while (got < 8 && guard < 200) begin
            acc = in_valid && in_ready;
            if (acc) begin
                q.push_back(state_in);
                acc_cyc.push_back(cyc);
            end
            if (out_valid) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL stream extra: got %h expected nothing", state_out);
                end else begin
                    e = ref_imc(q.pop_front());
                    if (state_out !== e) begin
                        n_bad++;
                        $display("FAIL stream %0d: got %h expected %h", got, state_out, e);
                    end
                end
                got++;
            end
            tick();
            guard++;
            if (acc) begin
                sent++;
                if (sent < 8) state_in = v[sent];
                else          in_valid = 1'b0;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_cmp++;
        if (got != 8 || acc_cyc.size() != 8) begin
            n_bad++;
            $display("FAIL stream count: got %0d outputs %0d accepts expected 8", got, acc_cyc.size());
        end
        for (int i = 1; i < acc_cyc.size(); i++) begin
            n_cmp++;
            if (acc_cyc[i] - acc_cyc[i-1] != 6) begin
                n_bad++;
                $display("FAIL stream spacing %0d: got %0d expected 6", i, acc_cyc[i] - acc_cyc[i-1]);
            end
        end
    endtask

    initial begin
        reset        = 1'b1;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        state_in     = '0;
        rt_valid     = 1'b0;
        rt_data      = '0;
        rt_out_ready = 1'b0;
        test_reset();
        test_fips();
        test_backpressure();
        test_reset_mid();
        test_round_trip();
        test_throughput();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/inv_mix_columns_seq.md
# inv_mix_columns_seq

Sequential AES InvMixColumns unit for the decryption datapath. It is the inverse of the existing column-transform logic. It accepts one 128-bit AES state over a valid/ready handshake and processes one 32-bit column per clock through a shared GF(2^8) multiply network. The result is returned over a second valid/ready handshake. It sits between InvSubBytes/InvShiftRows and AddRoundKey in decryption rounds 1..Nr-1.

## Interface
- `INVERSE`, default 1. 1 selects the InvMixColumns matrix (0e 0b 0d 09). 0 selects the forward MixColumns matrix (02 03 01 01), for round-trip checking only.
- `clk`  input  1  Sole clock; all state updates on its rising edge.
- `reset`  input  1  Reset is synchronous and active-high.
- `in_valid`  input  1  `state_in` is valid this cycle.
- `in_ready`  output  1  Block can accept a state this cycle.
- `state_in`  input  128  Input AES state, FIPS-197 byte order.
- `out_valid`  output  1  `state_out` holds a complete result.
- `out_ready`  input  1  Downstream accepts `state_out` this cycle.
- `state_out`  output  128  Transformed state; stable while `out_valid`=1.
- `busy`  output  1  High in COL or DONE.

## Operation
- Byte order: byte k of the state is `state_in[127-8k -: 8]`. Column c is bytes 4c..4c+3, with row 0 at the top (most significant) byte.
- Per column (a0..a3) -> (b0..b3), with INVERSE=1:
  - b0 = 0e·a0 ^ 0b·a1 ^ 0d·a2 ^ 09·a3.
  - Each row rotates the coefficients right by one: b1 = 09·a0 ^ 0e·a1 ^ 0b·a2 ^ 0d·a3, and so on.
- GF arithmetic: xtime(x) = (x<<1) ^ (x[7] ? 8'h1b : 8'h00). The reduction is conditional on the MSB and never applied unconditionally.
  - 09 = x8^x; 0b = x8^x2^x; 0d = x8^x4^x; 0e = x8^x4^x2, where x2/x4/x8 are repeated xtime.
  - All results are 8 bits; no carries escape.
- Datapath: one combinational column engine feeds a 128-bit working register. A 2-bit column counter `col` selects the input column and the destination slot.
- FSM states:
  - IDLE: `in_ready`=1. On `in_valid`&&`in_ready`, latch `state_in` into the input register, set `col`=0, go to COL.
  - COL: each cycle, write the result for column `col` into the working register and increment `col`. After the write with `col`=3, go to DONE. `col` wraps 3->0.
  - DONE: `out_valid`=1 and `state_out`=working register. On `out_ready`=1, go to IDLE. Otherwise hold indefinitely with `state_out` unchanged.
- `in_ready` = (state==IDLE). `in_valid` is ignored outside IDLE, and the input register is not overwritten.
- Simultaneous events:
  - In DONE with `out_ready`=1 and `in_valid`=1, the new state is not accepted that cycle, because `in_ready`=0. It is accepted the following cycle in IDLE.
  - `reset` takes priority over every other input in every state.

## Timing
- Reset (on the clock edge with `reset`=1), from any state including mid-COL:
  - state=IDLE, `col`=0, `out_valid`=0, `busy`=0, `state_out`=128'h0, working register cleared.
  - `in_ready`=1 from the first cycle after reset.
  - Any in-flight block is discarded; no partial result is ever presented.
- Accept on edge T. Columns 0..3 are written on edges T+1..T+4. `out_valid` rises after edge T+4, so latency is 4 cycles from accept to first `out_valid`.
- With `out_ready` held at 1:
  - The transfer occurs on edge T+5.
  - IDLE is entered after T+5, and the next accept can occur on edge T+6.
  - Sustained throughput is one state per 6 cycles.
- Backpressure: while `out_valid`=1 and `out_ready`=0, `state_out` and `out_valid` are stable every cycle.
- No combinational path from `in_valid` to `in_ready`, or from `out_ready` to `out_valid`.

## Test plan
- Reset values: assert `reset` for 2 cycles, then release. Required: `out_valid`=0, `busy`=0, `state_out`=0, `in_ready`=1. No `out_valid` appears without an input.
- FIPS column vectors: send one state built from columns 8e4da1bc, 9fdc589d, 4d7ebdf8, c6c6c6c6 (in that order). Required: result columns db135345, f20a225c, 2d26314c, c6c6c6c6, with `out_valid` exactly 4 cycles after accept.
- Backpressure: send the state from the previous test and hold `out_ready`=0 for 10 cycles, also driving `in_valid`=1 with a different state. Required: `state_out` is stable, the second state is not accepted, and it is accepted on the cycle after `out_ready` releases the first.
- Reset mid-operation: accept a state, assert `reset` on the edge where `col`=2. Required: no `out_valid` for the aborted block, and the next accepted state of all-01 bytes yields all-01 bytes.
- Round trip with reduction: instantiate INVERSE=0 feeding INVERSE=1, and drive 1000 random states including all-ff and all-80 (MSB-set reduction cases). Required: the output equals the input for every state, in order, with no drops.
- Throughput: stream 8 back-to-back states with `in_valid`=1 and `out_ready`=1. Required: accepts are exactly 6 cycles apart and the 8 outputs emerge in order.
